// File: rtl/prio_enc_pkg.sv
// Package: prio_enc_pkg
// Shared definitions for the registered priority encoder.
//   PRIO_N_DEFAULT : default number of request lines
//   PRIO_MAX_N     : widest vector onehot() can produce
//   prio_state_e   : output slot state (EMPTY / PRESENT)
//   clog2_safe     : code width, never below 1
//   onehot         : one-hot mask for an index
package prio_enc_pkg;

    localparam int unsigned PRIO_N_DEFAULT = 8;
    localparam int unsigned PRIO_MAX_N     = 64;

    typedef enum logic {
        StEmpty   = 1'b0,
        StPresent = 1'b1
    } prio_state_e;

    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [PRIO_MAX_N-1:0] onehot(input int unsigned idx);
        return {{(PRIO_MAX_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/prio_find_first.sv
// Module: prio_find_first
// Combinational search for the first set bit of vec, scanning upward from
// index start and wrapping at N.
//   vec   in  N  candidate vector
//   start in  W  first index examined
//   found out 1  any bit of vec set
//   idx   out W  first set index at or after start (0 when none)
module prio_find_first
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = PRIO_N_DEFAULT,
    parameter int unsigned W = clog2_safe(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] pos;

    always_comb begin
        found = |vec;
        idx   = '0;
        pos   = '0;
        // Walk offsets from farthest to nearest so the nearest hit is written last.
        for (int unsigned k = 0; k < N; k++) begin
            pos = W'((32'(start) + (N - 1 - k)) % N);
            if (vec[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/prio_req_encoder.sv
// Module: prio_req_encoder
// Registered priority encoder with sticky request capture and a valid/ready
// output slot. Request pulses accumulate in a pending register; the winner is
// presented on code and held until the consumer accepts it.
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   req_in     in   N  request lines, bit i set => line i pending from next edge
//   flush      in   1  synchronous clear of pending and the output slot
//   code_ready in   1  consumer accepts code this cycle
//   code_valid out  1  code holds a granted index
//   code       out  W  granted index
//   pending    out  N  pending vector (presented line included until accepted)
// Build option: define PRIO_ROUND_ROBIN_EN for round-robin selection;
// otherwise the lowest set index wins.
module prio_req_encoder
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = PRIO_N_DEFAULT,
    parameter int unsigned W = clog2_safe(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         flush,
    input  logic         code_ready,
    output logic         code_valid,
    output logic [W-1:0] code,
    output logic [N-1:0] pending
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] code_q, code_d;
    logic         code_valid_q, code_valid_d;

    prio_state_e  state;
    logic         acc;
    logic         load;
    logic [N-1:0] avail;
    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] sel_idx;

    assign state = code_valid_q ? StPresent : StEmpty;
    assign acc   = (state == StPresent) & code_ready;
    assign load  = (state == StEmpty) | acc;
    // Set wins over clear: a line re-requested in its accept cycle stays pending.
    assign avail = (pending_q & ~(acc ? N'(onehot(32'(code_q))) : '0)) | req_in;

`ifdef PRIO_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] last_grant;

    // The grant accepted this cycle already counts as last served, so the
    // same-cycle reload searches past it.
    assign last_grant = acc ? code_q : ptr_q;
    assign start      = (32'(last_grant) == N - 1) ? '0 : last_grant + W'(1);

    always_comb begin
        ptr_d = ptr_q;
        if (acc && !flush) begin
            ptr_d = code_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start = '0;
`endif

    prio_find_first #(
        .N(N),
        .W(W)
    ) u_find_first (
        .vec  (avail),
        .start(start),
        .found(found),
        .idx  (sel_idx)
    );

    always_comb begin
        pending_d    = avail;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        if (load) begin
            code_valid_d = found;
            code_d       = found ? sel_idx : '0;
        end
        // Flush overrides both the accept and any same-cycle requests.
        if (flush) begin
            pending_d    = '0;
            code_valid_d = 1'b0;
            code_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
        end
    end

    assign code_valid = code_valid_q;
    assign code       = code_q;
    assign pending    = pending_q;

endmodule
